// File: rtl/le_cmd_queue.sv
// Line-engine command queue: CPU stores fill shadow registers, "go" pushes a
// snapshot into a circular FIFO, and a replay FSM strobes each entry to the engine.
module le_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_wr_en,
  input  logic [2:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_status,
  output logic        cpu_full,
  input  logic        LE_ready,
  output logic [31:0] LE_color,
  output logic [9:0]  LE_point,
  output logic        LE_color_valid,
  output logic        LE_x0_valid,
  output logic        LE_y0_valid,
  output logic        LE_x1_valid,
  output logic        LE_y1_valid,
  output logic        LE_trigger
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] color;
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic [9:0]  x1;
    logic [9:0]  y1;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_COLOR, ST_X0, ST_Y0, ST_X1, ST_Y1, ST_TRIG, ST_WAIT
  } state_t;

  entry_t        mem_r [DEPTH];
  logic [31:0]   sh_color_r;
  logic [9:0]    sh_x0_r, sh_y0_r, sh_x1_r, sh_y1_r;
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;
  logic          ovf_r;
  state_t        state_r, state_nx_s;
  logic          wait_hold_r;

  logic          go_s, clr_s, full_s, empty_s, pop_s, push_s, ovf_evt_s;
  entry_t        head_s;
  logic [5:0]    strobe_nx_s;
  logic [9:0]    point_nx_s;
  logic [31:0]   color_nx_s;

  // A pop frees a slot on the same edge, so a push into a full queue still lands.
  assign go_s      = cpu_wr_en && (cpu_addr == 3'd5);
  assign clr_s     = cpu_wr_en && (cpu_addr == 3'd6);
  assign full_s    = (count_r == FULL_CNT);
  assign empty_s   = (count_r == '0);
  assign pop_s     = (state_r == ST_TRIG);
  assign push_s    = go_s && (!full_s || pop_s);
  assign ovf_evt_s = go_s && full_s && !pop_s;
  assign head_s    = mem_r[rd_ptr_r];
  assign cpu_full  = full_s;

  // Status word assembled from registered count and flags.
  always_comb begin
    cpu_status           = 32'h0000_0000;
    cpu_status[31]       = ovf_r;
    cpu_status[AW+1]     = full_s;
    cpu_status[AW]       = empty_s;
    cpu_status[AW-1:0]   = count_r[AW-1:0];
  end

  // Shadow registers capture CPU stores and persist across pushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_color_r <= 32'h0000_0000;
      sh_x0_r    <= 10'd0;
      sh_y0_r    <= 10'd0;
      sh_x1_r    <= 10'd0;
      sh_y1_r    <= 10'd0;
    end else if (cpu_wr_en) begin
      case (cpu_addr)
        3'd0:    sh_color_r <= cpu_wdata;
        3'd1:    sh_x0_r    <= cpu_wdata[9:0];
        3'd2:    sh_y0_r    <= cpu_wdata[9:0];
        3'd3:    sh_x1_r    <= cpu_wdata[9:0];
        3'd4:    sh_y1_r    <= cpu_wdata[9:0];
        default: ;
      endcase
    end
  end

  // Entry storage, written with the pre-store shadow snapshot.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= '{color: sh_color_r, x0: sh_x0_r, y0: sh_y0_r,
                           x1: sh_x1_r, y1: sh_y1_r};
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      ovf_r <= ovf_evt_s || (ovf_r && !clr_s);
    end
  end

  // Replay state register; wait_hold_r marks the first WAIT cycle after a trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      wait_hold_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      wait_hold_r <= (state_r == ST_TRIG);
    end
  end

  // Replay next state.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  if (!empty_s && LE_ready) state_nx_s = ST_COLOR;
      ST_COLOR: if (LE_ready) state_nx_s = ST_X0;
      ST_X0:    if (LE_ready) state_nx_s = ST_Y0;
      ST_Y0:    if (LE_ready) state_nx_s = ST_X1;
      ST_X1:    if (LE_ready) state_nx_s = ST_Y1;
      ST_Y1:    if (LE_ready) state_nx_s = ST_TRIG;
      ST_TRIG:  state_nx_s = ST_WAIT;
      ST_WAIT:  if (!wait_hold_r && LE_ready) state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Strobes fire on entry to a state, so they are registered yet meet entry latency.
  always_comb begin
    strobe_nx_s = 6'b00_0000;
    point_nx_s  = 10'd0;
    color_nx_s  = LE_color;
    if (state_nx_s != state_r) begin
      case (state_nx_s)
        ST_COLOR: strobe_nx_s = 6'b00_0001;
        ST_X0:    strobe_nx_s = 6'b00_0010;
        ST_Y0:    strobe_nx_s = 6'b00_0100;
        ST_X1:    strobe_nx_s = 6'b00_1000;
        ST_Y1:    strobe_nx_s = 6'b01_0000;
        ST_TRIG:  strobe_nx_s = 6'b10_0000;
        default:  strobe_nx_s = 6'b00_0000;
      endcase
    end else begin
      strobe_nx_s = 6'b00_0000;
    end
    case (state_nx_s)
      ST_COLOR: color_nx_s = head_s.color;
      ST_X0:    point_nx_s = head_s.x0;
      ST_Y0:    point_nx_s = head_s.y0;
      ST_X1:    point_nx_s = head_s.x1;
      ST_Y1:    point_nx_s = head_s.y1;
      default:  point_nx_s = 10'd0;
    endcase
  end

  // Registered engine outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      LE_color       <= 32'h0000_0000;
      LE_point       <= 10'd0;
      LE_color_valid <= 1'b0;
      LE_x0_valid    <= 1'b0;
      LE_y0_valid    <= 1'b0;
      LE_x1_valid    <= 1'b0;
      LE_y1_valid    <= 1'b0;
      LE_trigger     <= 1'b0;
    end else begin
      LE_color       <= color_nx_s;
      LE_point       <= point_nx_s;
      LE_color_valid <= strobe_nx_s[0];
      LE_x0_valid    <= strobe_nx_s[1];
      LE_y0_valid    <= strobe_nx_s[2];
      LE_x1_valid    <= strobe_nx_s[3];
      LE_y1_valid    <= strobe_nx_s[4];
      LE_trigger     <= strobe_nx_s[5];
    end
  end

endmodule

// File: tb/tb_le_cmd_queue.sv
// Bench for le_cmd_queue: directed scenarios plus random traffic against a
// queue-based reference model and a replay protocol scoreboard.
module tb_le_cmd_queue;
  logic        clk = 1'b0;
  logic        rst, cpu_wr_en, LE_ready;
  logic [2:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_status, LE_color;
  logic        cpu_full;
  logic [9:0]  LE_point;
  logic        LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger;

  le_cmd_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_status(cpu_status), .cpu_full(cpu_full),
    .LE_ready(LE_ready), .LE_color(LE_color), .LE_point(LE_point),
    .LE_color_valid(LE_color_valid), .LE_x0_valid(LE_x0_valid),
    .LE_y0_valid(LE_y0_valid), .LE_x1_valid(LE_x1_valid),
    .LE_y1_valid(LE_y1_valid), .LE_trigger(LE_trigger)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: queue of {color,x0,y0,x1,y1}, shadow values, sticky flag.
  logic [71:0] mq[$];
  logic [31:0] sh_color;
  logic [9:0]  sh_p [4];
  bit          m_ovf;
  int          phase;      // next strobe expected: 0 color .. 4 y1, 5 trigger
  int          trig_age;
  int          stall_cnt;
  bit          last_trig;
  logic [5:0]  sv_obs;
  bit          log_en;
  logic [9:0]  x0_log[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int sz;
    sz = mq.size();
    s = 32'h0;
    s[31] = m_ovf;
    s[3] = (sz == 4);
    s[2] = (sz == 0);
    s[1:0] = 2'(sz % 4);
    return s;
  endfunction

  task automatic observe(input bit was_rst, input bit rdy_c, input int qsize_c);
    logic [71:0] head;
    int kind;
    sv_obs = {LE_trigger, LE_y1_valid, LE_x1_valid, LE_y0_valid, LE_x0_valid, LE_color_valid};
    check_val("status", cpu_status, exp_status());
    check_val("full", cpu_full, (mq.size() == 4));
    check_val("onehot", ($countones(sv_obs) > 1), 0);
    if (trig_age < 1000) trig_age++;
    if (was_rst) begin
      check_val("rst_strobes", sv_obs, 0);
      check_val("rst_point", LE_point, 0);
      check_val("rst_color", LE_color, 0);
      stall_cnt = 0;
    end else if (sv_obs != 6'b0) begin
      kind = 0;
      for (int i = 0; i < 6; i++) if (sv_obs[i]) kind = i;
      check_val("order", kind, phase);
      check_val("ready_before", rdy_c, 1);
      check_val("nonempty", (mq.size() != 0), 1);
      head = (mq.size() != 0) ? mq[0] : 72'h0;
      if (kind == 0) begin
        check_val("gap", (trig_age >= 4), 1);
        check_val("color_data", LE_color, head[71:40]);
      end else if (kind <= 4) begin
        check_val("point_data", LE_point, 10'(head >> (10 * (4 - kind))));
        if (kind == 1 && log_en) x0_log.push_back(LE_point);
      end else begin
        trig_age = 0;
      end
      phase = (kind + 1) % 6;
      stall_cnt = 0;
    end else if (phase != 0) begin
      check_val("advance", rdy_c, 0);
    end else begin
      check_val("idle_point", LE_point, 0);
      if (rdy_c && qsize_c > 0) stall_cnt++;
      else stall_cnt = 0;
      check_val("stall", (stall_cnt >= 4), 0);
    end
    last_trig = was_rst ? 1'b0 : LE_trigger;
  endtask

  // One clock: drive inputs, advance the model across the edge, then observe.
  task automatic step(input bit wr, input logic [2:0] a, input logic [31:0] d, input bit rdy, input bit r);
    bit full_pre, pop;
    int qsize_c;
    cpu_wr_en = wr; cpu_addr = a; cpu_wdata = d; LE_ready = rdy; rst = r;
    qsize_c = mq.size();
    if (r) begin
      mq.delete();
      sh_color = 32'h0;
      for (int i = 0; i < 4; i++) sh_p[i] = 10'd0;
      m_ovf = 1'b0; phase = 0; trig_age = 1000;
    end else begin
      full_pre = (mq.size() == 4);
      pop = last_trig;
      if (pop) void'(mq.pop_front());
      if (wr) begin
        if (a == 3'd0) sh_color = d;
        else if (a <= 3'd4) sh_p[int'(a) - 1] = d[9:0];
        else if (a == 3'd5) begin
          if (full_pre && !pop) m_ovf = 1'b1;
          else mq.push_back({sh_color, sh_p[0], sh_p[1], sh_p[2], sh_p[3]});
        end else if (a == 3'd6) m_ovf = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    observe(r, rdy, qsize_c);
  endtask

  initial begin
    int exp_pt[6] = '{0, 10, 20, 100, 50, 0};
    int exp_x0[5] = '{1, 2, 3, 4, 6};
    logic [31:0] one;
    bit found;
    bit rdy_hi;
    one = 32'd1;
    log_en = 1'b0;
    last_trig = 1'b0;
    stall_cnt = 0;
    step(0, 3'd0, 32'h0, 0, 1);
    step(0, 3'd0, 32'h0, 0, 1);
    check_val("reset_status", cpu_status, 32'h4);

    // Basic command with exact latency
    step(1, 3'd0, 32'h00FF_0000, 1, 0);
    step(1, 3'd1, 32'd10, 1, 0);
    step(1, 3'd2, 32'd20, 1, 0);
    step(1, 3'd3, 32'd100, 1, 0);
    step(1, 3'd4, 32'd50, 1, 0);
    step(1, 3'd5, 32'h0, 1, 0);
    check_val("lat_count", cpu_status, 32'h1);
    for (int i = 0; i < 6; i++) begin
      step(0, 3'd0, 32'h0, 1, 0);
      check_val("lat_strobe", sv_obs, one << i);
      check_val("lat_point", LE_point, exp_pt[i]);
      if (i == 0) check_val("lat_color", LE_color, 32'h00FF_0000);
    end
    step(0, 3'd0, 32'h0, 1, 0);
    check_val("drain", cpu_status, 32'h4);
    for (int i = 0; i < 4; i++) step(0, 3'd0, 32'h0, 1, 0);

    // Held engine, fill, overflow, clear
    for (int i = 1; i <= 3; i++) begin
      step(1, 3'd1, i, 0, 0);
      step(1, 3'd5, 32'h0, 0, 0);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 3'd0, 32'h0, 0, 0);
      check_val("held_quiet", sv_obs, 0);
    end
    check_val("held_count", cpu_status, 32'h3);
    step(1, 3'd1, 32'd4, 0, 0);
    step(1, 3'd5, 32'h0, 0, 0);
    step(1, 3'd1, 32'd5, 0, 0);
    step(1, 3'd5, 32'h0, 0, 0);
    check_val("ovf_status", cpu_status, 32'h8000_0008);
    check_val("ovf_full", cpu_full, 1);
    step(1, 3'd6, 32'h0, 0, 0);
    check_val("ovf_clear", cpu_status, 32'h8);
    step(1, 3'd1, 32'd6, 0, 0);

    // Release; push on the TRIG pop cycle of a full queue
    log_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, 3'd0, 32'h0, 1, 0);
      if (sv_obs[5]) found = 1'b1;
    end
    check_val("wait_trig", found, 1);
    step(1, 3'd5, 32'h0, 1, 0);
    check_val("pop_push_count", cpu_status, 32'h8);
    for (int i = 0; i < 80; i++) step(0, 3'd0, 32'h0, 1, 0);
    check_val("fifo_len", x0_log.size(), 5);
    for (int i = 0; i < 5 && i < x0_log.size(); i++) check_val("fifo_order", x0_log[i], exp_x0[i]);
    check_val("drained", cpu_status, 32'h4);
    log_en = 1'b0;

    // Engine stalls while in X1
    step(1, 3'd3, 32'd300, 1, 0);
    step(1, 3'd5, 32'h0, 1, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 3'd0, 32'h0, 1, 0);
      if (sv_obs[3]) found = 1'b1;
    end
    check_val("wait_x1", found, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 3'd0, 32'h0, 0, 0);
      check_val("x1_hold_quiet", sv_obs, 0);
      check_val("x1_hold_point", LE_point, 300);
    end
    step(0, 3'd0, 32'h0, 1, 0);
    check_val("x1_resume", sv_obs, 32'h10);
    for (int i = 0; i < 10; i++) step(0, 3'd0, 32'h0, 1, 0);

    // Reset in the middle of a replay
    step(1, 3'd5, 32'h0, 1, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 3'd0, 32'h0, 1, 0);
      if (sv_obs[2]) found = 1'b1;
    end
    check_val("wait_y0", found, 1);
    step(1, 3'd5, 32'h0, 1, 1);
    check_val("rst_mid_status", cpu_status, 32'h4);
    for (int i = 0; i < 10; i++) begin
      step(0, 3'd0, 32'h0, 1, 0);
      check_val("no_strobe_after_rst", sv_obs, 0);
    end

    // Random traffic
    rdy_hi = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      bit r, wr, rdy;
      logic [2:0] a;
      if (c % 150 == 0) rdy_hi = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 499) == 0);
      wr = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 3) == 0) ? 3'd5 : 3'($urandom_range(0, 7));
      rdy = rdy_hi ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 2);
      step(wr, a, $urandom, rdy, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
